// File: rtl/mrly_spi_pkg.sv
// Constants and state encoding shared by the SPI relay write and read paths.
package mrly_spi_pkg;

  localparam logic [7:0] INST_READ  = 8'h03;
  localparam logic [7:0] INST_WRITE = 8'h02;

  localparam int HEADER_BITS = 24;
  localparam int DATA_BITS   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_IGNORE
  } spi_state_e;

endpackage

// File: rtl/spi_input_sync.sv
// Brings the asynchronous SPI pins into the clk domain and detects sclk/cs_n edges.
module spi_input_sync (
  input  logic clk,
  input  logic reset,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi
);

  // bit0/bit1 form the synchronizer, bit2 is the previous synchronized value
  logic [2:0] sclk_pipe_q, sclk_pipe_d;
  logic [2:0] cs_pipe_q, cs_pipe_d;
  logic [1:0] mosi_pipe_q, mosi_pipe_d;

  always_comb begin
    sclk_pipe_d = {sclk_pipe_q[1:0], spi_sclk};
    cs_pipe_d   = {cs_pipe_q[1:0], spi_cs_n};
    mosi_pipe_d = {mosi_pipe_q[0], spi_mosi};
  end

  // cs_n resets to its inactive level so leaving reset never fakes an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_pipe_q <= 3'b000;
      cs_pipe_q   <= 3'b111;
      mosi_pipe_q <= 2'b00;
    end else begin
      sclk_pipe_q <= sclk_pipe_d;
      cs_pipe_q   <= cs_pipe_d;
      mosi_pipe_q <= mosi_pipe_d;
    end
  end

  assign sclk_rise = sclk_pipe_q[1] & ~sclk_pipe_q[2];
  assign cs_fall   = ~cs_pipe_q[1] & cs_pipe_q[2];
  assign cs_rise   = cs_pipe_q[1] & ~cs_pipe_q[2];
  assign mosi      = mosi_pipe_q[1];

endmodule

// File: rtl/spi2mem_writer.sv
// SPI mode-0 write-frame receiver that updates the relay memory image in the clk domain.
module spi2mem_writer
  import mrly_spi_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic [WIDTH-1:0]  memory,
  output logic              wr_strobe,
  output logic [15:0]       wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_err
);

  localparam int          BYTES     = WIDTH / 8;
  localparam logic [16:0] BYTES_EXT = 17'(BYTES);

  logic sclk_rise, cs_fall, cs_rise, mosi;

  spi_input_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .sclk_rise (sclk_rise),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .mosi      (mosi)
  );

  spi_state_e        state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [15:0]       addr_q, addr_d;
  logic [WIDTH-1:0]  mem_q, mem_d;
  logic [15:0]       wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic              frame_err_q, frame_err_d;

  logic [23:0] shift_in;
  logic [16:0] addr_inc;

  assign shift_in = {shift_q[22:0], mosi};
  // 17-bit increment so address 0xFFFF runs out of range instead of wrapping to 0
  assign addr_inc = {1'b0, addr_q} + 17'd1;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    mem_d       = mem_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;

    if (cs_rise) begin
      // cs_n deassertion wins over a coincident sclk edge; a partial byte is dropped
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      if ((state_q == ST_HEADER || state_q == ST_DATA) && bit_cnt_q != 5'd0)
        frame_err_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d   = ST_HEADER;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        ST_HEADER: begin
          if (sclk_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'(HEADER_BITS - 1)) begin
              addr_d = shift_in[15:0];
              if (shift_in[23:16] != INST_WRITE) begin
                state_d = ST_IGNORE;
              end else if ({1'b0, shift_in[15:0]} < BYTES_EXT) begin
                state_d   = ST_DATA;
                bit_cnt_d = '0;
              end else begin
                state_d     = ST_IGNORE;
                frame_err_d = 1'b1;
              end
            end
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'(DATA_BITS - 1)) begin
              for (int i = 0; i < BYTES; i++) begin
                if (addr_q == 16'(i)) mem_d[i*8 +: 8] = shift_in[7:0];
              end
              wr_addr_d   = addr_q;
              wr_data_d   = shift_in[7:0];
              wr_strobe_d = 1'b1;
              addr_d      = addr_inc[15:0];
              bit_cnt_d   = '0;
              if (addr_inc >= BYTES_EXT) state_d = ST_IGNORE;
            end
          end
        end
        ST_IGNORE: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      mem_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      mem_q       <= mem_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign memory    = mem_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi2mem_writer.sv
// Scoreboard bench for spi2mem_writer: frame-level reference model feeds an event queue checked by a monitor.
module tb_spi2mem_writer;

  localparam int WIDTH = 16;
  localparam int BYTES = WIDTH / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic [WIDTH-1:0]  memory;
  logic              wr_strobe;
  logic [15:0]       wr_addr;
  logic [7:0]        wr_data;
  logic              frame_err;

  always #5 clk = ~clk;

  spi2mem_writer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .memory    (memory),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err)
  );

  typedef struct {
    bit               is_err;
    logic [15:0]      addr;
    logic [7:0]       data;
    logic [WIDTH-1:0] mem;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_mem [BYTES];
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic logic [WIDTH-1:0] model_image();
    logic [WIDTH-1:0] img;
    for (int i = 0; i < BYTES; i++) img[i*8 +: 8] = model_mem[i];
    return img;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < BYTES; i++) model_mem[i] = 8'h00;
  endtask

  task automatic push_ev(input bit is_err, input int a, input logic [7:0] d);
    ev_t e;
    e.is_err = is_err;
    e.addr   = 16'(a);
    e.data   = d;
    e.mem    = model_image();
    exp_q.push_back(e);
  endtask

  // Frame-level rules: what a frame of nbits bits should produce
  task automatic model_frame(input logic [23:0] hdr, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3, input int nbits);
    logic [7:0] dat [4];
    int k, part, a;
    dat = '{d0, d1, d2, d3};
    if (nbits < 24) begin
      if (nbits > 0) push_ev(1'b1, 0, 8'h00);
      return;
    end
    if (hdr[23:16] != 8'h02) return;
    a = int'(hdr[15:0]);
    if (a >= BYTES) begin
      push_ev(1'b1, 0, 8'h00);
      return;
    end
    k    = (nbits - 24) / 8;
    part = (nbits - 24) % 8;
    for (int j = 0; j < k; j++) begin
      if (a >= BYTES) return;
      model_mem[a] = dat[j];
      push_ev(1'b0, a, dat[j]);
      a++;
    end
    if (part > 0 && a < BYTES) push_ev(1'b1, 0, 8'h00);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe or error pulse must match the next queued event
  always @(negedge clk) begin
    if (wr_strobe || frame_err) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got strobe=%0b err=%0b addr=%0h data=%0h, expected no pulse",
                 wr_strobe, frame_err, wr_addr, wr_data);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.is_err) begin
          if (!(frame_err === 1'b1 && wr_strobe === 1'b0)) begin
            n_bad++;
            $display("FAIL err_pulse: got strobe=%0b err=%0b, expected err only", wr_strobe, frame_err);
          end
        end else if (!(wr_strobe === 1'b1 && frame_err === 1'b0 && wr_addr === e.addr &&
                       wr_data === e.data && memory === e.mem)) begin
          n_bad++;
          $display("FAIL write_pulse: got strobe=%0b err=%0b addr=%0h data=%0h mem=%0h, expected addr=%0h data=%0h mem=%0h",
                   wr_strobe, frame_err, wr_addr, wr_data, memory, e.addr, e.data, e.mem);
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [55:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = bits[55-i];
      clks(3);
      spi_sclk = 1'b1;
      clks(3);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic end_of_frame(input string name);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_memory"}, 32'(memory), 32'(model_image()));
    exp_q.delete();
  endtask

  task automatic run_frame(input string name, input logic [23:0] hdr, input logic [7:0] d0,
                           input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                           input int nbits);
    model_frame(hdr, d0, d1, d2, d3, nbits);
    spi_cs_n = 1'b0;
    clks(4);
    send_bits({hdr, d0, d1, d2, d3}, nbits);
    clks(3);
    spi_cs_n = 1'b1;
    clks(8);
    end_of_frame(name);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_memory"}, 32'(memory), 32'd0);
    chk({name, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({name, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({name, "_wr_strobe"}, 32'(wr_strobe), 32'd0);
    chk({name, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  inst;
    logic [15:0] addr;
    int          nbits, r;

    reset    = 1'b1;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    model_clear();
    clks(3);
    chk_all_zero("reset");
    reset = 1'b0;
    clks(1);
    chk("after_reset_strobe", 32'(wr_strobe), 32'd0);
    chk("after_reset_err", 32'(frame_err), 32'd0);
    clks(2);

    run_frame("single_write", 24'h020001, 8'hA5, 8'h00, 8'h00, 8'h00, 32);
    chk("single_image", 32'(memory), 32'h0000A500);
    chk("single_wr_addr", 32'(wr_addr), 32'd1);
    chk("single_wr_data", 32'(wr_data), 32'hA5);
    run_frame("burst_overflow", 24'h020000, 8'h11, 8'h22, 8'h33, 8'h00, 48);
    chk("burst_image", 32'(memory), 32'h00002211);
    run_frame("out_of_range", 24'h020002, 8'h55, 8'h00, 8'h00, 8'h00, 32);
    run_frame("addr_ffff", 24'h02FFFF, 8'h66, 8'h00, 8'h00, 8'h00, 32);
    run_frame("read_inst", 24'h030001, 8'h5A, 8'h00, 8'h00, 8'h00, 32);
    run_frame("truncated_data", 24'h020000, 8'hF0, 8'h00, 8'h00, 8'h00, 28);
    run_frame("after_trunc", 24'h020000, 8'h7E, 8'h00, 8'h00, 8'h00, 32);
    chk("after_trunc_low", 32'(memory[7:0]), 32'h7E);
    run_frame("short_header", 24'h020000, 8'h00, 8'h00, 8'h00, 8'h00, 10);
    run_frame("empty_frame", 24'h020000, 8'h00, 8'h00, 8'h00, 8'h00, 0);

    // Reset in the middle of a header with a fully set image
    run_frame("fill_ff", 24'h020000, 8'hFF, 8'hFF, 8'h00, 8'h00, 40);
    chk("fill_ff_image", 32'(memory), 32'h0000FFFF);
    spi_cs_n = 1'b0;
    clks(4);
    send_bits({24'h020001, 32'h0}, 12);
    reset = 1'b1;
    clks(1);
    chk_all_zero("mid_reset");
    reset = 1'b0;
    model_clear();
    clks(3);
    spi_cs_n = 1'b1;
    clks(8);
    end_of_frame("mid_reset_tail");
    run_frame("post_reset", 24'h020001, 8'h3C, 8'h00, 8'h00, 8'h00, 32);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 5);
      inst = (r <= 3) ? 8'h02 : (r == 4) ? 8'h03 : 8'($urandom);
      r = $urandom_range(0, 4);
      addr = (r == 0) ? 16'h0000 : (r == 1) ? 16'h0001 : (r == 2) ? 16'h0002 :
             (r == 3) ? 16'hFFFF : 16'($urandom);
      r = $urandom_range(0, 5);
      if (r == 0) nbits = $urandom_range(0, 23);
      else nbits = 24 + 8 * $urandom_range(0, 4) + ((r == 5) ? $urandom_range(1, 7) : 0);
      if (nbits > 56) nbits = 56;
      run_frame("random", {inst, addr}, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), nbits);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
